// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: field widths and the responder state encoding.
package bus_pkg;

    localparam int BUS_ADDR_BITS = 16;
    localparam int BUS_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_WRITE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_DATA
    } slave_state_e;

endpackage

// File: rtl/slave_port.sv
// Responder end of the serial system bus: deserializes address/write data,
// drives one local write or read, and serializes read data back with split.
module slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int SPLIT_THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     mode,
    input  logic                     wr_bus,
    input  logic                     master_valid,
    output logic                     slave_ready,
    output logic                     rd_bus,
    output logic                     slave_valid,
    input  logic                     master_ready,
    output logic                     split,
    output logic [ADDR_WIDTH-1:0]    s_addr,
    output logic [BUS_DATA_BITS-1:0] s_wr_data,
    output logic                     s_wr_en,
    output logic                     s_rd_en,
    input  logic [BUS_DATA_BITS-1:0] s_rd_data,
    input  logic                     s_rd_valid
);

    localparam logic [3:0] ADDR_LAST  = 4'(BUS_ADDR_BITS - 1);
    localparam logic [3:0] DATA_LAST  = 4'(BUS_DATA_BITS - 1);
    localparam logic [3:0] THRESH_M1  = 4'(SPLIT_THRESH - 1);
    localparam logic [3:0] WAIT_MAX   = 4'hF;

    slave_state_e state, state_d;

    logic [3:0]               bit_cnt;
    logic [3:0]               wait_cnt;
    logic [ADDR_WIDTH-1:0]    addr_sr;
    logic [BUS_DATA_BITS-1:0] data_sr;
    logic [BUS_DATA_BITS-1:0] rd_sr;
    logic                     split_d;
    logic                     in_xfer;
    logic                     out_xfer;

    assign s_addr    = addr_sr;
    assign s_wr_data = data_sr;
    assign in_xfer   = master_valid & slave_ready;
    assign out_xfer  = slave_valid & master_ready;

    always_comb begin
        state_d     = state;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        rd_bus      = 1'b0;
        s_wr_en     = 1'b0;
        s_rd_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                slave_ready = 1'b1;
                if (master_valid) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                slave_ready = 1'b1;
                if (!master_valid)
                    state_d = ST_IDLE;
                else if (bit_cnt == ADDR_LAST)
                    state_d = mode ? ST_WDATA : ST_RD_REQ;
            end
            ST_WDATA: begin
                slave_ready = 1'b1;
                if (!master_valid)
                    state_d = ST_IDLE;
                else if (bit_cnt == DATA_LAST)
                    state_d = ST_WRITE;
            end
            ST_WRITE: begin
                s_wr_en = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RD_REQ: begin
                s_rd_en = 1'b1;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (s_rd_valid) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                slave_valid = 1'b1;
                rd_bus      = rd_sr[BUS_DATA_BITS-1];
                if (master_ready && bit_cnt == DATA_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // wait_cnt counts from the s_rd_en cycle, so split registers high
    // exactly SPLIT_THRESH cycles after the request and drops on capture.
    assign split_d = ((state == ST_RD_REQ) || (state == ST_RD_WAIT && !s_rd_valid))
                     && (wait_cnt >= THRESH_M1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            addr_sr  <= '0;
            data_sr  <= '0;
            rd_sr    <= '0;
            split    <= 1'b0;
        end else begin
            state <= state_d;
            split <= split_d;

            if (state_d != state)
                bit_cnt <= (state == ST_IDLE) ? 4'd1 : 4'd0;
            else if (((state == ST_ADDR || state == ST_WDATA) && in_xfer) || out_xfer)
                bit_cnt <= bit_cnt + 4'd1;

            if (state == ST_RD_REQ || state == ST_RD_WAIT) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end

            // Only the local address bits are kept; upper bus bits shift out.
            if ((state == ST_IDLE || state == ST_ADDR) && in_xfer)
                addr_sr <= {addr_sr[ADDR_WIDTH-2:0], wr_bus};

            if (state == ST_WDATA && in_xfer)
                data_sr <= {data_sr[BUS_DATA_BITS-2:0], wr_bus};

            if (state == ST_RD_WAIT && s_rd_valid)
                rd_sr <= s_rd_data;
            else if (out_xfer)
                rd_sr <= {rd_sr[BUS_DATA_BITS-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: a per-cycle expectation timeline built from
// the bus timing rules, checked every cycle, plus literal transaction checks.
module tb_slave_port;

    localparam int AW     = 12;
    localparam int THRESH = 4;
    localparam int N      = 1024;

    logic          clk          = 1'b0;
    logic          rstn         = 1'b1;
    logic          mode         = 1'b0;
    logic          wr_bus       = 1'b0;
    logic          master_valid = 1'b0;
    logic          master_ready = 1'b0;
    logic          s_rd_valid   = 1'b0;
    logic [7:0]    s_rd_data    = 8'h00;
    logic          slave_ready, rd_bus, slave_valid, split, s_wr_en, s_rd_en;
    logic [AW-1:0] s_addr;
    logic [7:0]    s_wr_data;

    slave_port #(.ADDR_WIDTH(AW), .SPLIT_THRESH(THRESH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .mode         (mode),
        .wr_bus       (wr_bus),
        .master_valid (master_valid),
        .slave_ready  (slave_ready),
        .rd_bus       (rd_bus),
        .slave_valid  (slave_valid),
        .master_ready (master_ready),
        .split        (split),
        .s_addr       (s_addr),
        .s_wr_data    (s_wr_data),
        .s_wr_en      (s_wr_en),
        .s_rd_en      (s_rd_en),
        .s_rd_data    (s_rd_data),
        .s_rd_valid   (s_rd_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per cycle; untouched cycles mean "idle".
    logic          exp_ready [N];
    logic          exp_wr    [N];
    logic          exp_rd    [N];
    logic          exp_split [N];
    logic          exp_valid [N];
    logic          exp_bit   [N];
    logic          exp_ca    [N];
    logic          exp_cd    [N];
    logic [AW-1:0] exp_addr  [N];
    logic [7:0]    exp_data  [N];

    int            errors = 0;
    int            checks = 0;
    int            wr_pulses = 0;
    int            rd_pulses = 0;
    int            split_cycles = 0;
    int            last_wr_cyc = -1;
    logic [AW-1:0] last_wr_addr = '0;
    logic [7:0]    last_wr_data = '0;
    bit            running = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            int c;
            c = cyc;
            check("slave_ready", 32'(slave_ready), 32'(exp_ready[c]));
            check("s_wr_en",     32'(s_wr_en),     32'(exp_wr[c]));
            check("s_rd_en",     32'(s_rd_en),     32'(exp_rd[c]));
            check("split",       32'(split),       32'(exp_split[c]));
            check("slave_valid", 32'(slave_valid), 32'(exp_valid[c]));
            if (exp_valid[c]) check("rd_bus", 32'(rd_bus), 32'(exp_bit[c]));
            if (exp_ca[c])    check("s_addr", 32'(s_addr), 32'(exp_addr[c]));
            if (exp_cd[c])    check("s_wr_data", 32'(s_wr_data), 32'(exp_data[c]));
            if (s_wr_en) begin
                wr_pulses++;
                last_wr_cyc  = c;
                last_wr_addr = s_addr;
                last_wr_data = s_wr_data;
            end
            if (s_rd_en) rd_pulses++;
            if (split)   split_cycles++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        for (int i = 0; i < 24; i++) begin
            mode         = 1'b1;
            master_valid = 1'b1;
            wr_bus       = (i < 16) ? a[15-i] : d[23-i];
            step();
        end
        master_valid        = 1'b0;
        wr_bus              = 1'b0;
        exp_ready[cyc]      = 1'b0;
        exp_wr[cyc]         = 1'b1;
        exp_ca[cyc]         = 1'b1;
        exp_addr[cyc]       = a[AW-1:0];
        exp_cd[cyc]         = 1'b1;
        exp_data[cyc]       = d;
        step();
    endtask

    task automatic do_read(input logic [15:0] a, input int lat, input logic [7:0] d,
                           input logic [7:0] pat, input int plen, output logic [7:0] got);
        int k;
        int idx;
        logic mr;
        for (int i = 0; i < 16; i++) begin
            mode         = 1'b0;
            master_valid = 1'b1;
            wr_bus       = a[15-i];
            step();
        end
        master_valid   = 1'b0;
        wr_bus         = 1'b0;
        s_rd_data      = ~d;
        exp_ready[cyc] = 1'b0;
        exp_rd[cyc]    = 1'b1;
        exp_ca[cyc]    = 1'b1;
        exp_addr[cyc]  = a[AW-1:0];
        for (int t = 1; t <= lat; t++) begin
            step();
            exp_ready[cyc] = 1'b0;
            if (t >= THRESH) exp_split[cyc] = 1'b1;
            s_rd_valid = (t == lat);
            s_rd_data  = (t == lat) ? d : ~d;
        end
        step();
        s_rd_valid = 1'b0;
        s_rd_data  = 8'h00;
        k   = 0;
        idx = 0;
        got = 8'h00;
        while (k < 8) begin
            mr             = pat[idx % plen];
            master_ready   = mr;
            exp_ready[cyc] = 1'b0;
            exp_valid[cyc] = 1'b1;
            exp_bit[cyc]   = d[7-k];
            if (mr) begin
                got = {got[6:0], rd_bus};
                k++;
            end
            idx++;
            step();
        end
        master_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] got;
        int         s0;
        int         c0;
        logic [15:0] abort_addr;
        logic [15:0] rst_addr;

        for (int i = 0; i < N; i++) begin
            exp_ready[i] = 1'b1;
            exp_wr[i]    = 1'b0;
            exp_rd[i]    = 1'b0;
            exp_split[i] = 1'b0;
            exp_valid[i] = 1'b0;
            exp_bit[i]   = 1'b0;
            exp_ca[i]    = 1'b0;
            exp_cd[i]    = 1'b0;
            exp_addr[i]  = '0;
            exp_data[i]  = '0;
        end
        #1 rstn = 1'b0;
        running = 1'b1;
        exp_ca[1] = 1'b1;
        exp_cd[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        step();

        // Continuous write; strobe lands on the 25th cycle from the first bit.
        c0 = cyc;
        do_write(16'h0A5C, 8'hC3);
        check("wr_cycle", 32'(last_wr_cyc), 32'(c0 + 24));
        check("wr_addr",  32'(last_wr_addr), 32'h0A5C);
        check("wr_data",  32'(last_wr_data), 32'hC3);
        check("wr_count", 32'(wr_pulses), 32'd1);

        // Fast read back-to-back with the write: no split.
        s0 = split_cycles;
        do_read(16'h0123, 2, 8'h96, 8'b1, 1, got);
        check("rd_fast_data",  32'(got), 32'h96);
        check("rd_fast_split", 32'(split_cycles - s0), 32'd0);

        // Slow read: split for cycles 4..10 after s_rd_en.
        s0 = split_cycles;
        do_read(16'h0456, 10, 8'h3C, 8'b1, 1, got);
        check("rd_slow_data",  32'(got), 32'h3C);
        check("rd_slow_split", 32'(split_cycles - s0), 32'd7);
        step();
        step();

        // Abandoned address phase, then a full write.
        abort_addr = 16'h0FFF;
        for (int i = 0; i < 6; i++) begin
            mode         = 1'b1;
            master_valid = 1'b1;
            wr_bus       = abort_addr[15-i];
            step();
        end
        master_valid = 1'b0;
        step();
        step();
        check("abort_no_wr", 32'(wr_pulses), 32'd1);
        do_write(16'h0FFF, 8'h5A);
        check("abort_wr_count", 32'(wr_pulses), 32'd2);
        check("abort_wr_addr",  32'(last_wr_addr), 32'hFFF);
        check("abort_wr_data",  32'(last_wr_data), 32'h5A);

        // Read with master_ready stalls.
        do_read(16'h0ABC, 3, 8'hA7, 8'b1001, 4, got);
        check("rd_stall_data", 32'(got), 32'hA7);

        // Reset in the 4th write-data bit.
        rst_addr = 16'h0777;
        for (int i = 0; i < 19; i++) begin
            mode         = 1'b1;
            master_valid = 1'b1;
            wr_bus       = (i < 16) ? rst_addr[15-i] : 1'b1;
            step();
        end
        wr_bus        = 1'b1;
        rstn          = 1'b0;
        exp_ca[cyc]   = 1'b1;
        exp_addr[cyc] = '0;
        exp_cd[cyc]   = 1'b1;
        exp_data[cyc] = '0;
        step();
        rstn          = 1'b1;
        master_valid  = 1'b0;
        exp_ca[cyc]   = 1'b1;
        exp_addr[cyc] = '0;
        exp_cd[cyc]   = 1'b1;
        exp_data[cyc] = '0;
        step();
        check("rst_no_wr", 32'(wr_pulses), 32'd2);
        do_write(16'h1234, 8'h81);
        check("rst_wr_count", 32'(wr_pulses), 32'd3);
        check("rst_wr_addr",  32'(last_wr_addr), 32'h234);
        check("rst_wr_data",  32'(last_wr_data), 32'h81);

        step();
        step();
        check("rd_count", 32'(rd_pulses), 32'd3);
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
